// File: rtl/axil_load_master.sv
// AXI-Lite read initiator for core loads: one AR/R transaction per request,
// byte/half/word lane selection with sign or zero extension, error and timeout reporting.
module axil_load_master #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
    // resp_valid is a one-cycle strobe with no backpressure.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AR     = 3'd1,
        S_R_WAIT = 3'd2,
        S_DONE   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              timed_out_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              misaligned;
    logic              timeout_hit;
    logic [7:0]        byte_l;
    logic [15:0]       half_l;
    logic [31:0]       lane_ext;

    logic              req_ready_d, resp_valid_d, resp_err_d, arvalid_d, rready_d;
    logic [31:0]       resp_data_d, araddr_d;

    logic              unused_rresp0;
    assign unused_rresp0 = axi_rresp[0];

    assign dbg_state   = state_q;
    assign accept      = (state_q == S_IDLE) && req_valid;
    assign misaligned  = (req_size == 2'b11)
                       || ((req_size == 2'b01) && req_addr[0])
                       || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign timeout_hit = (state_q == S_R_WAIT) && !axi_rvalid
                       && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Lane select uses the offset/size latched at request time, not the live inputs.
    always_comb begin
        byte_l   = 8'(axi_rdata >> {off_q, 3'b000});
        half_l   = off_q[1] ? axi_rdata[31:16] : axi_rdata[15:0];
        lane_ext = axi_rdata;
        case (size_q)
            2'b00:   lane_ext = {{24{signed_q & byte_l[7]}}, byte_l};
            2'b01:   lane_ext = {{16{signed_q & half_l[15]}}, half_l};
            default: lane_ext = axi_rdata;
        endcase
    end

    // State register plus registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_err    <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_araddr  <= 32'd0;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_data   <= resp_data_d;
            resp_err    <= resp_err_d;
            axi_arvalid <= arvalid_d;
            axi_rready  <= rready_d;
            axi_araddr  <= araddr_d;
            if (accept) begin
                off_q       <= req_addr[1:0];
                size_q      <= req_size;
                signed_q    <= req_signed;
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
            if ((state_q == S_AR) && axi_arready) begin
                cnt_q <= '0;
            end else if ((state_q == S_R_WAIT) && !axi_rvalid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = misaligned ? S_DONE : S_AR;
            S_AR:     if (axi_arready) state_d = S_R_WAIT;
            S_R_WAIT: if (axi_rvalid || timeout_hit) state_d = S_DONE;
            S_DONE:   state_d = timed_out_q ? S_DRAIN : S_IDLE;
            S_DRAIN:  if (axi_rvalid) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        arvalid_d    = (state_d == S_AR);
        rready_d     = (state_d == S_R_WAIT) || (state_d == S_DRAIN);
        resp_valid_d = (state_d == S_DONE);
        araddr_d     = accept ? req_addr : axi_araddr;
        resp_err_d   = 1'b0;
        resp_data_d  = 32'd0;
        if (accept && misaligned) begin
            resp_err_d = 1'b1;
        end else if ((state_q == S_R_WAIT) && axi_rvalid) begin
            resp_err_d  = axi_rresp[1];
            resp_data_d = axi_rresp[1] ? 32'd0 : lane_ext;
        end else if (timeout_hit) begin
            resp_err_d = 1'b1;
        end
    end

endmodule
